// File: rtl/mult_seq_arb.sv
// mult_seq_arb: round-robin two-port sequencer for a shared unsigned shift-add multiplier.
// Define MULT_SEQ_ARB_ZERO_SKIP_EN to finish zero-operand jobs one cycle after capture.
module mult_seq_arb #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [2*WIDTH-1:0] f,
    output logic               busy
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state;
    logic [2*WIDTH-1:0] acc, mcand, acc_next, res;
    logic [WIDTH-1:0]   mplr;
    logic [CW-1:0]      cnt;
    logic               last, win1, fin;
    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign win1     = req1 & (~req0 | ~last);
    assign acc_next = mplr[0] ? acc + mcand : acc;
    assign busy     = state != IDLE;
`ifdef MULT_SEQ_ARB_ZERO_SKIP_EN
    logic skip;
    assign fin = skip || cnt == CW'(WIDTH - 1);
    assign res = skip ? '0 : acc_next;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            skip <= 1'b0;
        else if (state == IDLE && (req0 || req1))
            skip <= win1 ? (a1 == '0 || b1 == '0) : (a0 == '0 || b0 == '0);
`else
    assign fin = cnt == CW'(WIDTH - 1);
    assign res = acc_next;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            f     <= '0;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req0 || req1) begin
                    state <= BUSY;
                    gnt0  <= ~win1;
                    gnt1  <= win1;
                    last  <= win1;
                    acc   <= '0;
                    mcand <= {{WIDTH{1'b0}}, win1 ? a1 : a0};
                    mplr  <= win1 ? b1 : b0;
                    cnt   <= '0;
                end
                BUSY: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (fin) begin
                        state <= DONE;
                        f     <= res;
                        done0 <= gnt0;
                        done1 <= gnt1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
